fwd_scoreboard_unit: RTL and testbench
======================================

Name: fwd_scoreboard_unit

Overview:
Parametrised forwarding and hazard unit for the pipelined core. It keeps a registered record of every in-flight producer between the EX/MEM and WB stages. From these records it selects, for each of NUM_SRC source operands of the instruction in EX, the youngest matching producer, and it does the same for the flag (CCR) consumer. It raises a one-cycle load-use stall that the previous purely combinational forwarding logic could not express. It sits between the decode/reg-read pipeline register and the EX operand muxes.

Parameters:
REG_ADDR_W, 3, register address width
NUM_SRC, 2, number of source-operand channels in EX
DEPTH, 3, tracked producer stages (1=EX/MEM, 2=MEM/WB, 3=WB)
SEL_W, $clog2(DEPTH+1), forward-select width per channel

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
issue_valid  in  1  instruction in EX is valid and leaves EX this cycle unless stalled
issue_dest  in  REG_ADDR_W  destination register of EX instruction
issue_dest_we  in  1  EX instruction writes issue_dest
issue_kind  in  2  result source: 0 ALU, 1 LOAD, 2 LHI, 3 PC+1
issue_flag_we  in  1  EX instruction writes CCR
src_addr  in  NUM_SRC*REG_ADDR_W  source register addresses of EX instruction
src_used  in  NUM_SRC  channel actually reads its register
uses_flags  in  1  EX instruction is conditional on CCR (ADC/ADZ/NDC/NDZ)
cancel_ex_mem  in  1  producer in stage 1 failed its condition; suppress its writes
flush  in  1  kill EX instruction (branch redirect)
fwd_sel  out  NUM_SRC*SEL_W  0 = register file, k = stage k record
fwd_kind  out  NUM_SRC*2  kind of selected producer
fwd_flag_sel  out  SEL_W  0 = architectural CCR, k = stage k
stall  out  1  hold PC, IF/ID, ID/EX; insert bubble into EX/MEM

Behaviour:
- Record rec[k], k=1..DEPTH, holds {valid, dest, we, flag_we, kind}.
- Reset (async, reset=0): all rec.valid=0. Consequently fwd_sel=0, fwd_kind=0, fwd_flag_sel=0, stall=0.
- Effective stage-1 write enables: we1 = rec[1].we & ~cancel_ex_mem, flag_we1 likewise. They are used both for matching and for the shift this cycle.
- Each rising edge: rec[k+1] <= rec[k] for k<DEPTH, with the stage-1 enables masked as above. rec[DEPTH] retires.
- rec[1] is loaded as follows:
  - if stall or flush or ~issue_valid: bubble (valid=0);
  - else: the issue_* fields.
- Channel match (combinational): channel c finds the lowest k with rec[k].valid & eff_we & dest==src_addr[c] & src_used[c]. If found, fwd_sel=k and fwd_kind=rec[k].kind; otherwise fwd_sel=0 and fwd_kind=0.
- Flag match: the lowest k with valid & eff_flag_we gives fwd_flag_sel=k. This is gated by uses_flags; when uses_flags=0, fwd_flag_sel=0.
- Load-use: stall=1 if any channel's match is k=1 with kind LOAD, or if the flag match is k=1 with kind LOAD. While stall=1, all fwd_sel and fwd_flag_sel are forced to 0.
- After a stall, the load sits in rec[2], so the next cycle gives fwd_sel=2 with kind LOAD. A stall therefore never exceeds one cycle for a single producer.
- flush and stall asserted together: flush wins for the record (bubble), and stall is still reported.
- cancel_ex_mem with no valid rec[1]: no effect.
- Multiple stages matching the same register: the youngest (smallest k) wins.
- A reset deasserted mid-operation restarts with an empty scoreboard. There is no partial state.
- Output latency: outputs are combinational on the current records; records have a 1-cycle update.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- When defined: adds output stall_cnt [15:0]. It resets to 0, increments on every cycle with stall=1, and saturates at 16'hFFFF. It is not cleared by flush.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - the kind encoding constants (KIND_ALU, KIND_LOAD, KIND_LHI, KIND_PC1);
  - the record typedef;
  - the SEL_W function.
- One sub-module, fwd_match_chan: a priority search over the records for one source address, returning sel, kind and a load-use flag. It is instantiated NUM_SRC times plus once for flags.

Test Plan:
- Reset low for 3 cycles with random inputs, then release -> fwd_sel=0, fwd_flag_sel=0 and stall=0 until the first issue.
- ADD R3 issued, then consumer with src0=R3 -> fwd_sel[0]=1, kind=ALU. One cycle later with the same src -> fwd_sel[0]=2.
- LW R2 issued, then consumer src1=R2 -> stall=1 for exactly 1 cycle, then fwd_sel[1]=2, kind=LOAD. With FWD_STALL_CNT_EN, stall_cnt=1.
- ADD R4 then LHI R4 back-to-back, consumer src0=R4 -> fwd_sel[0]=1, kind=LHI (youngest wins).
- ADC with cancel_ex_mem=1 in stage 1, older ADD R5 in stage 2, consumer src0=R5 -> fwd_sel[0]=2. Cancelled record never matches in later stages.
- flush=1 on issue of JAL R6, consumer src0=R6 next cycle -> fwd_sel[0]=0. ADZ with uses_flags after LW in stage 1 -> stall=1.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: producer kind codes, the per-stage
// record layout and the forward-select width helper.
package fwd_pkg;

    // Records hold addresses at this fixed width; narrower register files zero-extend.
    localparam int REC_ADDR_W = 8;

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_LHI  = 2'd2;
    localparam logic [1:0] KIND_PC1  = 2'd3;

    typedef struct packed {
        logic                  valid;
        logic [REC_ADDR_W-1:0] dest;
        logic                  we;
        logic                  flag_we;
        logic [1:0]            kind;
    } fwd_rec_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match_chan.sv
// Priority search over the in-flight producer records for one consumer channel;
// the youngest (lowest-index) matching stage wins.
module fwd_match_chan
    import fwd_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int SEL_W   = 2,
    parameter bit IS_FLAG = 1'b0
) (
    input  fwd_rec_t [DEPTH-1:0]  recs,
    input  logic [REC_ADDR_W-1:0] addr,
    input  logic                  used,
    output logic [SEL_W-1:0]      sel,
    output logic [1:0]            kind,
    output logic                  load_hit
);

    logic [DEPTH-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IS_FLAG)
                hit[i] = recs[i].valid & used & recs[i].flag_we;
            else
                hit[i] = recs[i].valid & used & recs[i].we & (recs[i].dest == addr);
        end
    end

    // Walk from oldest to youngest so the youngest hit is the last one written.
    always_comb begin
        sel  = '0;
        kind = KIND_ALU;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel  = SEL_W'(i + 1);
                kind = recs[i].kind;
            end
        end
    end

    assign load_hit = hit[0] & (recs[0].kind == KIND_LOAD);

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard scoreboard: tracks producers EX/MEM..WB, selects forward sources
// and raises the load-use stall. Define FWD_STALL_CNT_EN to add the stall_cnt output.
module fwd_scoreboard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = fwd_sel_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_dest,
    input  logic                          issue_dest_we,
    input  logic [1:0]                    issue_kind,
    input  logic                          issue_flag_we,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic                          uses_flags,
    input  logic                          cancel_ex_mem,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic [NUM_SRC*2-1:0]          fwd_kind,
    output logic [SEL_W-1:0]              fwd_flag_sel,
`ifdef FWD_STALL_CNT_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          stall
);

    fwd_rec_t [DEPTH-1:0] rec_q;
    fwd_rec_t [DEPTH-1:0] rec_eff;
    fwd_rec_t             rec_in;

    logic [NUM_SRC-1:0][SEL_W-1:0] chan_sel;
    logic [NUM_SRC-1:0]            chan_lu;
    logic [SEL_W-1:0]              flag_sel;
    logic [1:0]                    flag_kind;
    logic                          flag_lu;

    // A failed-condition producer in stage 1 loses its enables for matching now
    // and for every later stage it shifts into.
    always_comb begin
        rec_eff            = rec_q;
        rec_eff[0].we      = rec_q[0].we & ~cancel_ex_mem;
        rec_eff[0].flag_we = rec_q[0].flag_we & ~cancel_ex_mem;
    end

    always_comb begin
        rec_in = '0;
        if (issue_valid && !stall && !flush) begin
            rec_in.valid   = 1'b1;
            rec_in.dest    = REC_ADDR_W'(issue_dest);
            rec_in.we      = issue_dest_we;
            rec_in.flag_we = issue_flag_we;
            rec_in.kind    = issue_kind;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rec_q <= '0;
        end else begin
            rec_q[0] <= rec_in;
            for (int i = DEPTH - 1; i >= 1; i--)
                rec_q[i] <= rec_eff[i-1];
        end
    end

    for (genvar c = 0; c < NUM_SRC; c++) begin : g_chan
        fwd_match_chan #(
            .DEPTH   (DEPTH),
            .SEL_W   (SEL_W),
            .IS_FLAG (1'b0)
        ) u_chan (
            .recs     (rec_eff),
            .addr     (REC_ADDR_W'(src_addr[c*REG_ADDR_W +: REG_ADDR_W])),
            .used     (src_used[c]),
            .sel      (chan_sel[c]),
            .kind     (fwd_kind[c*2 +: 2]),
            .load_hit (chan_lu[c])
        );
        assign fwd_sel[c*SEL_W +: SEL_W] = stall ? '0 : chan_sel[c];
    end

    fwd_match_chan #(
        .DEPTH   (DEPTH),
        .SEL_W   (SEL_W),
        .IS_FLAG (1'b1)
    ) u_flag (
        .recs     (rec_eff),
        .addr     ('0),
        .used     (uses_flags),
        .sel      (flag_sel),
        .kind     (flag_kind),
        .load_hit (flag_lu)
    );

    assign stall        = (|chan_lu) | (flag_lu & (flag_kind == KIND_LOAD));
    assign fwd_flag_sel = stall ? '0 : flag_sel;

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed + random bench for fwd_scoreboard_unit against a queue-based producer model.
`timescale 1ns/1ps
module tb_fwd_scoreboard_unit;
    localparam int AW = 3;
    localparam int NS = 2;
    localparam int D  = 3;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset;
    logic issue_valid, issue_dest_we, issue_flag_we, uses_flags, cancel_ex_mem, flush;
    logic [AW-1:0] issue_dest;
    logic [1:0] issue_kind;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0] src_used;
    logic [NS*SW-1:0] fwd_sel;
    logic [NS*2-1:0] fwd_kind;
    logic [SW-1:0] fwd_flag_sel;
    logic stall;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fwd_scoreboard_unit #(.REG_ADDR_W(AW), .NUM_SRC(NS), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_dest_we(issue_dest_we), .issue_kind(issue_kind), .issue_flag_we(issue_flag_we),
        .src_addr(src_addr), .src_used(src_used), .uses_flags(uses_flags),
        .cancel_ex_mem(cancel_ex_mem), .flush(flush), .fwd_sel(fwd_sel), .fwd_kind(fwd_kind),
        .fwd_flag_sel(fwd_flag_sel),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .stall(stall));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: producers in age order, hist[0] = newest (stage 1).
    typedef struct { bit v; int dest; bit we; bit fwe; int kind; } ent_t;
    ent_t hist[$];
    int e_sel[NS];
    int e_kind[NS];
    int e_fl;
    bit e_st;
    int m_cnt;

    function automatic void model_clear();
        ent_t b = '{0, 0, 0, 0, 0};
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back(b);
        m_cnt = 0;
    endfunction

    function automatic bit writes_reg(int k);
        return hist[k].v && hist[k].we && !(k == 0 && cancel_ex_mem);
    endfunction

    function automatic void model_eval();
        e_st = 0;
        for (int c = 0; c < NS; c++) begin
            int want = int'(src_addr[c*AW +: AW]);
            e_sel[c] = 0; e_kind[c] = 0;
            if (src_used[c]) begin
                for (int k = 0; k < D; k++) begin
                    if (writes_reg(k) && hist[k].dest == want) begin
                        e_sel[c] = k + 1; e_kind[c] = hist[k].kind;
                        break;
                    end
                end
            end
            if (e_sel[c] == 1 && e_kind[c] == 1) e_st = 1;
        end
        e_fl = 0;
        if (uses_flags) begin
            for (int k = 0; k < D; k++) begin
                if (hist[k].v && hist[k].fwe && !(k == 0 && cancel_ex_mem)) begin
                    e_fl = k + 1;
                    if (k == 0 && hist[k].kind == 1) e_st = 1;
                    break;
                end
            end
        end
        if (e_st) begin
            for (int c = 0; c < NS; c++) e_sel[c] = 0;
            e_fl = 0;
        end
    endfunction

    function automatic void model_adv();
        ent_t n = '{0, 0, 0, 0, 0};
        if (cancel_ex_mem) begin hist[0].we = 0; hist[0].fwe = 0; end
        if (issue_valid && !e_st && !flush)
            n = '{1, int'(issue_dest), issue_dest_we, issue_flag_we, int'(issue_kind)};
        hist.push_front(n);
        void'(hist.pop_back());
        if (e_st && m_cnt < 65535) m_cnt++;
    endfunction

    // Inputs only change just after posedge, so the negedge sees what the next edge samples.
    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (!reset) model_clear();
            model_eval();
            for (int c = 0; c < NS; c++) begin
                check($sformatf("sel%0d", c), int'(fwd_sel[c*SW +: SW]), e_sel[c]);
                check($sformatf("kind%0d", c), int'(fwd_kind[c*2 +: 2]), e_kind[c]);
            end
            check("flag_sel", int'(fwd_flag_sel), e_fl);
            check("stall", int'(stall), int'(e_st));
`ifdef FWD_STALL_CNT_EN
            check("stall_cnt", int'(stall_cnt), m_cnt);
`endif
            if (reset) model_adv();
        end
    end

    task automatic drive(bit v, int d, bit we, int k, bit fwe, int s0, int s1,
                         bit u0, bit u1, bit uf, bit can, bit fl);
        issue_valid = v; issue_dest = AW'(d); issue_dest_we = we; issue_kind = 2'(k);
        issue_flag_we = fwe; src_addr = {AW'(s1), AW'(s0)}; src_used = {u1, u0};
        uses_flags = uf; cancel_ex_mem = can; flush = fl;
    endtask

    task automatic step(bit v, int d, bit we, int k, bit fwe, int s0, int s1,
                        bit u0, bit u1, bit uf, bit can, bit fl);
        drive(v, d, we, k, fwe, s0, s1, u0, u1, uf, can, fl);
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic rand_in();
        drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0));
    endtask

    initial begin
        reset = 1'b0;
        rand_in();
        repeat (3) begin @(posedge clk); #1; rand_in(); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 3, 2, 1, 1, 1, 0, 0);
        check("idle_sel0", int'(fwd_sel[1:0]), 0);
        check("idle_stall", int'(stall), 0);
        adv();
        // ADD R3 then consumer
        step(1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); adv();
        step(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        check("add_fwd_s1", int'(fwd_sel[1:0]), 1);
        check("add_kind", int'(fwd_kind[1:0]), 0);
        adv();
        step(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        check("add_fwd_s2", int'(fwd_sel[1:0]), 2);
        adv();
        // LW R2 load-use
        step(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); adv();
        step(1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
        check("lu_stall", int'(stall), 1);
        check("lu_sel_forced", int'(fwd_sel[3:2]), 0);
        adv();
        step(1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
        check("lu_release", int'(stall), 0);
        check("lu_sel2", int'(fwd_sel[3:2]), 2);
        check("lu_kind", int'(fwd_kind[3:2]), 1);
`ifdef FWD_STALL_CNT_EN
        check("lu_cnt", int'(stall_cnt), 1);
`endif
        adv();
        // ADD R4 then LHI R4: youngest wins
        step(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); adv();
        step(1, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0); adv();
        step(0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0);
        check("young_sel", int'(fwd_sel[1:0]), 1);
        check("young_kind", int'(fwd_kind[1:0]), 2);
        adv();
        // ADD R5, ADC R5 cancelled
        step(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); adv();
        step(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); adv();
        step(0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 1, 0);
        check("cancel_sel", int'(fwd_sel[1:0]), 2);
        adv();
        step(0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0);
        check("cancel_later", int'(fwd_sel[1:0]), 3);
        adv();
        // flushed JAL R6
        step(1, 6, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1); adv();
        step(0, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0);
        check("flush_sel", int'(fwd_sel[1:0]), 0);
        adv();
        // LW R1 writing CCR, then ADZ
        step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0); adv();
        step(1, 0, 0, 0, 0, 2, 3, 1, 1, 1, 0, 0);
        check("flag_stall", int'(stall), 1);
        check("flag_forced", int'(fwd_flag_sel), 0);
        adv();
        step(1, 0, 0, 0, 0, 2, 3, 1, 1, 1, 0, 0);
        check("flag_release", int'(stall), 0);
        check("flag_sel2", int'(fwd_flag_sel), 2);
        adv();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flag_gated", int'(fwd_flag_sel), 0);
        adv();
        // flush together with stall
        step(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); adv();
        step(1, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 1);
        check("flush_stall", int'(stall), 1);
        adv();
        step(0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0);
        check("flush_stall_after", int'(fwd_sel[1:0]), 2);
        adv();
        // reset mid-operation
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); adv();
        drive(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("midrst_sel", int'(fwd_sel[1:0]), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("postrst_sel", int'(fwd_sel[1:0]), 0);
        adv();
        // random traffic against the model
        repeat (400) begin rand_in(); adv(); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) adv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
